// File: rtl/alb_pkg.sv
// Shared definitions for the ALB multi-precision sequencer: op codes,
// FSM state encoding and the arithmetic-op predicate.
package alb_pkg;

  localparam logic [1:0] ALB_SUB = 2'b00;
  localparam logic [1:0] ALB_AND = 2'b01;
  localparam logic [1:0] ALB_ADD = 2'b10;
  localparam logic [1:0] ALB_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic is_arith(input logic [1:0] op);
    return (op == ALB_SUB) || (op == ALB_ADD);
  endfunction

endpackage

// File: rtl/alb_mpseq_if.sv
// Bundle of the request, response and ALB-side signals of the sequencer.
// slave = sequencer side, master = requester/consumer plus the ALB itself.
interface alb_mpseq_if #(
  parameter int NBYTES = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [8*NBYTES-1:0]   req_a;
  logic [8*NBYTES-1:0]   req_b;
  logic                  req_cin;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [8*NBYTES-1:0]   rsp_f;
  logic                  rsp_c;
  logic                  rsp_z;
  logic                  rsp_n;
  logic                  rsp_v;

  logic [7:0]            alb_r;
  logic [7:0]            alb_s;
  logic                  alb_ci;
  logic [1:0]            alb_mi;
  logic [7:0]            alb_f;
  logic                  alb_co;
  logic                  alb_vo;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  alb_f, alb_co, alb_vo,
    output req_ready, rsp_valid, rsp_f, rsp_c, rsp_z, rsp_n, rsp_v,
    output alb_r, alb_s, alb_ci, alb_mi
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output alb_f, alb_co, alb_vo,
    input  req_ready, rsp_valid, rsp_f, rsp_c, rsp_z, rsp_n, rsp_v,
    input  alb_r, alb_s, alb_ci, alb_mi
  );

endinterface

// File: rtl/alb_mpseq.sv
// Multi-precision sequencer: issues an NBYTES-wide op to the 8-bit ALB one
// byte at a time (LSB first), chaining carries and building whole-word flags.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | ready for a request, ALB inputs parked at 0
//   ST_ISSUE | drive byte r_idx to the ALB, load latency counter
//   ST_WAIT  | hold ALB inputs, capture result when counter hits 1
//   ST_RESP  | response valid, held until rsp_ready
module alb_mpseq
  import alb_pkg::*;
#(
  parameter int NBYTES  = 4,
  parameter int ALB_LAT = 1
) (
  input  logic              clk,
  input  logic              resetb,
  alb_mpseq_if.slave        bus
);

  localparam int W    = 8 * NBYTES;
  localparam int IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW   = $clog2(ALB_LAT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cin;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_f;
  logic            r_carry;
  logic            r_v;
  logic            r_z;
  logic            w_capture;
  logic            w_last;

  assign w_capture = (r_state == ST_WAIT) && (r_cnt == CW'(1));
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (resetb) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.req_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_capture) w_state_nxt = w_last ? ST_RESP : ST_ISSUE;
      ST_RESP:  if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (r_state == ST_IDLE);
    bus.rsp_valid = (r_state == ST_RESP);
    bus.alb_r     = 8'h00;
    bus.alb_s     = 8'h00;
    bus.alb_ci    = 1'b0;
    bus.alb_mi    = 2'b00;
    if ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) begin
      bus.alb_r  = r_a[{r_idx, 3'b000} +: 8];
      bus.alb_s  = r_b[{r_idx, 3'b000} +: 8];
      bus.alb_mi = r_op;
      // Byte 0 takes the request carry; later bytes take the previous carry-out.
      bus.alb_ci = is_arith(r_op) & ((r_idx == '0) ? r_cin : r_carry);
    end
  end

  assign bus.rsp_f = r_f;
  assign bus.rsp_z = r_z;
  assign bus.rsp_n = r_f[W-1];
  assign bus.rsp_c = is_arith(r_op) & r_carry;
  assign bus.rsp_v = is_arith(r_op) & r_v;

  always_ff @(posedge clk) begin
    if (resetb) begin
      r_op    <= 2'b00;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_f     <= '0;
      r_carry <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_op  <= bus.req_op;
            r_a   <= bus.req_a;
            r_b   <= bus.req_b;
            r_cin <= bus.req_cin;
            r_idx <= '0;
            r_z   <= 1'b1;
          end
        end
        ST_ISSUE: r_cnt <= CW'(ALB_LAT);
        ST_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_capture) begin
            r_f[{r_idx, 3'b000} +: 8] <= bus.alb_f;
            r_carry <= bus.alb_co;
            r_v     <= bus.alb_vo;
            r_z     <= r_z & (bus.alb_f == 8'h00);
            if (!w_last) r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alb_mpseq.sv
// Directed bench for alb_mpseq with a 1-cycle registered 8-bit ALB model.
module tb_alb_mpseq;
  import alb_pkg::*;

  logic clk;
  logic resetb;
  int   total;
  int   bad;

  alb_mpseq_if #(.NBYTES(4)) bus ();

  alb_mpseq #(.NBYTES(4), .ALB_LAT(1)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference byte ALB: registered, one cycle of latency.
  logic [7:0] m_seff;
  logic [8:0] m_sum;
  logic [7:0] m_f;
  logic       m_co;
  logic       m_vo;
  always_comb begin
    m_seff = (bus.alb_mi == ALB_SUB) ? ~bus.alb_s : bus.alb_s;
    m_sum  = {1'b0, bus.alb_r} + {1'b0, m_seff} + {8'h00, bus.alb_ci};
    m_f    = m_sum[7:0];
    m_co   = m_sum[8];
    m_vo   = (bus.alb_r[7] == m_seff[7]) && (m_sum[7] != bus.alb_r[7]);
    if (bus.alb_mi == ALB_AND) begin
      m_f = bus.alb_r & bus.alb_s; m_co = 1'b0; m_vo = 1'b0;
    end else if (bus.alb_mi == ALB_OR) begin
      m_f = bus.alb_r | bus.alb_s; m_co = 1'b0; m_vo = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    bus.alb_f  <= m_f;
    bus.alb_co <= m_co;
    bus.alb_vo <= m_vo;
  end

  logic [31:0] res_f;
  logic        res_c, res_z, res_n, res_v, ci_seen, timed_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      ci_seen = ci_seen | bus.alb_ci;
      step();
      n++;
    end
    timed_out = (n >= 50);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin);
    int n;
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_cin = cin;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin step(); n++; end
    step();
    bus.req_valid = 1'b0;
    ci_seen = 1'b0;
    wait_rsp();
    res_f = bus.rsp_f; res_c = bus.rsp_c; res_z = bus.rsp_z;
    res_n = bus.rsp_n; res_v = bus.rsp_v;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v7, v8, ci_b1, quiet;
    total = 0; bad = 0;
    resetb = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_a = '0; bus.req_b = '0;
    bus.req_cin = 1'b0; bus.rsp_ready = 1'b0;
    step(); step();
    resetb = 1'b0;

    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_f", {32'd0, bus.rsp_f}, 64'd0);
    chk("rst_flags", {60'd0, bus.rsp_c, bus.rsp_z, bus.rsp_n, bus.rsp_v}, 64'd0);
    chk("rst_alb", {44'd0, bus.alb_r, bus.alb_s, bus.alb_ci, bus.alb_mi, 1'b0}, 64'd0);

    // ADD 0xFF + 1 with explicit latency and byte-1 carry check
    bus.req_op = ALB_ADD; bus.req_a = 32'h0000_00FF; bus.req_b = 32'h0000_0001;
    bus.req_cin = 1'b0; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    v7 = 1'b1; v8 = 1'b0; ci_b1 = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 2) ci_b1 = bus.alb_ci;
      if (n == 7) v7 = bus.rsp_valid;
      if (n == 8) v8 = bus.rsp_valid;
    end
    chk("lat_early", {63'd0, v7}, 64'd0);
    chk("lat_rise", {63'd0, v8}, 64'd1);
    chk("add1_ci_byte1", {63'd0, ci_b1}, 64'd1);
    chk("add1_f", {32'd0, bus.rsp_f}, 64'h0000_0100);
    chk("add1_flags", {60'd0, bus.rsp_c, bus.rsp_z, bus.rsp_n, bus.rsp_v}, 64'd0);
    bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;

    run_op(ALB_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("add2_to", {63'd0, timed_out}, 64'd0);
    chk("add2_f", {32'd0, res_f}, 64'd0);
    chk("add2_czv", {61'd0, res_c, res_z, res_v}, 64'b110);

    run_op(ALB_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("add3_f", {32'd0, res_f}, 64'h8000_0000);
    chk("add3_cnv", {61'd0, res_c, res_n, res_v}, 64'b011);

    run_op(ALB_SUB, 32'h0000_0005, 32'h0000_0005, 1'b1);
    chk("sub1_f", {32'd0, res_f}, 64'd0);
    chk("sub1_cz", {62'd0, res_c, res_z}, 64'b11);

    run_op(ALB_SUB, 32'h0000_0003, 32'h0000_0005, 1'b1);
    chk("sub2_f", {32'd0, res_f}, 64'hFFFF_FFFE);
    chk("sub2_cnzv", {60'd0, res_c, res_n, res_z, res_v}, 64'b0100);

    run_op(ALB_AND, 32'hF0F0_F0F0, 32'h0FF0_FF00, 1'b1);
    chk("and_f", {32'd0, res_f}, 64'h00F0_F000);
    chk("and_cv", {62'd0, res_c, res_v}, 64'd0);
    chk("and_ci", {63'd0, ci_seen}, 64'd0);

    run_op(ALB_OR, 32'hF0F0_F0F0, 32'h0FF0_FF00, 1'b0);
    chk("or_f", {32'd0, res_f}, 64'hFFF0_FFF0);
    chk("or_nz", {62'd0, res_n, res_z}, 64'b10);

    // Back-to-back with req_valid held high and a 5-cycle response stall
    bus.req_op = ALB_ADD; bus.req_a = 32'd1; bus.req_b = 32'd2; bus.req_cin = 1'b0;
    bus.req_valid = 1'b1;
    step();
    bus.req_a = 32'd10; bus.req_b = 32'd20;
    wait_rsp();
    chk("bp_to", {63'd0, timed_out}, 64'd0);
    chk("bp_f0", {32'd0, bus.rsp_f}, 64'd3);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_hold_f", {32'd0, bus.rsp_f}, 64'd3);
      chk("bp_hold_ready", {63'd0, bus.req_ready}, 64'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_retire_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("bp_retire_idle", {63'd0, bus.req_ready}, 64'd1);
    step();
    chk("bp_second_accept", {63'd0, bus.req_ready}, 64'd0);
    bus.req_valid = 1'b0;
    wait_rsp();
    chk("bp_f1", {32'd0, bus.rsp_f}, 64'd30);
    bus.rsp_ready = 1'b1; step(); bus.rsp_ready = 1'b0;

    // Reset while byte 2 is waiting on the ALB
    bus.req_op = ALB_ADD; bus.req_a = 32'h1122_3344; bus.req_b = 32'h0; bus.req_cin = 1'b0;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int n = 0; n < 5; n++) step();
    chk("mid_byte2", {56'd0, bus.alb_r}, 64'h22);
    resetb = 1'b1;
    step();
    resetb = 1'b0;
    chk("mid_rst_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("mid_rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_alb", {45'd0, bus.alb_r, bus.alb_s, bus.alb_ci, bus.alb_mi}, 64'd0);
    quiet = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      quiet = quiet | bus.rsp_valid;
    end
    chk("mid_no_rsp", {63'd0, quiet}, 64'd0);
    run_op(ALB_ADD, 32'd1, 32'd2, 1'b0);
    chk("post_rst_to", {63'd0, timed_out}, 64'd0);
    chk("post_rst_f", {32'd0, res_f}, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
